calc_seq_core: RTL and testbench
================================

// Module: calc_seq_core
// PURPOSE
//  Parametrised, self-sequencing successor to the smallCALC datapath. Built-in FSM replaces the
//  externally driven mux/write-enable/read-enable controls. One start pulse loads A and B into a
//  3-entry register file, executes one of 8 ALU ops and posts result + flags with a done pulse.
//  Accumulate mode chains operations on the previous result. Sits between operand source and display.
// PARAMETERS
//  WIDTH   3  operand/result width in bits (>=2)
//  ACC_EN  1  1: acc_mode honoured; 0: acc_mode ignored (A always from in1)
// PORTS
//  clk       in   1      single clock, all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; accepted only when busy=0
//  acc_mode  in   1      sampled at accept: 1 = operand A taken from previous result R2
//  op        in   3      ALU op code, sampled at accept
//  in1       in   WIDTH  operand A, sampled at accept
//  in2       in   WIDTH  operand B, sampled at accept
//  busy      out  1      high from accept edge until return to IDLE
//  done      out  1      one-cycle pulse: out/zero/carry freshly valid
//  out       out  WIDTH  registered result, held until next done
//  zero      out  1      out == 0
//  carry     out  1      add: carry-out; sub: borrow (A<B unsigned); shl/shr: bit shifted out; else 0
// BEHAVIOUR
//  - Reset: state=IDLE, R0..R2=0, op_q=0, b_q=0, busy=0, done=0, out=0, zero=0, carry=0.
//  - States: IDLE -> LOAD_B -> EXEC -> DONE -> IDLE; no waits, fixed timing.
//  - IDLE: start=1 at edge n => op_q<=op; R0<=(ACC_EN&&acc_mode)?R2:in1; b_q<=in2; go LOAD_B.
//  - LOAD_B (edge n+1): R1<=b_q; go EXEC.
//  - EXEC (edge n+2): R2,out<=ALU(R0,R1,op_q); zero/carry updated; done<=1; go DONE.
//  - DONE (edge n+3): done<=0; go IDLE. New start accepted from edge n+4 earliest.
//  - Latency: done visible in cycle after edge n+2; busy high during cycles n+1..n+3.
//  - start while busy=1: ignored, not queued; in1/in2/op may change freely after accept.
//  - Ops: 000 add, 001 sub, 010 and, 011 xor, 100 or, 101 shl1 (A<<1), 110 shr1 (A>>1), 111 passB.
//  - Arithmetic: all modulo 2^WIDTH, unsigned; carry from WIDTH+1-bit intermediate.
//  - Reset mid-operation (any state): abort, no R2/out write, done stays 0, all regs cleared.
//  - rst and start same edge: rst wins.
//  - acc_mode before any completed op: uses R2=0 (reset value).
// STRUCTURE
//  - calc_pkg: op code localparams (OP_ADD..OP_PASSB), state encodings, OPW=3.
//  - Sub-module calc_alu: combinational, params WIDTH; ports a,b,op -> y,carry; zero computed in core.
//  - Core: FSM, R0..R2, b_q, op_q, output/flag registers.
// TESTING (WIDTH=3 unless stated)
//  1. in1=5,in2=6,op=add,start -> done at n+2 cycle; out=3, carry=1, zero=0; busy 3 cycles.
//  2. in1=2,in2=5,op=sub -> out=5, carry=1; in1=7,in2=7,op=xor -> out=0, zero=1, carry=0.
//  3. add 3+2 -> out=5; then acc_mode=1,in1=7(ignored),in2=1,add -> out=6; ACC_EN=0 build -> out=0 (7+1).
//  4. start held high continuously with changing in1 -> exactly one accept per 4 cycles; results match
//     operands present at each accept edge only.
//  5. assert rst in EXEC after prior out=4 -> out=0, done never pulses, busy=0 next cycle; next op normal.
//  6. exhaustive: all in1,in2 (0..7) x 8 ops vs reference model; also WIDTH=8 random 2000 ops, ops 101/110 carry.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the self-sequencing calculator core.
//   OPW          : op code width
//   OP_ADD..     : ALU op codes
//   state_t      : sequencer state encoding, also exported on the core's fsm_state port
package calc_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD   = 3'b000;
    localparam logic [OPW-1:0] OP_SUB   = 3'b001;
    localparam logic [OPW-1:0] OP_AND   = 3'b010;
    localparam logic [OPW-1:0] OP_XOR   = 3'b011;
    localparam logic [OPW-1:0] OP_OR    = 3'b100;
    localparam logic [OPW-1:0] OP_SHL   = 3'b101;
    localparam logic [OPW-1:0] OP_SHR   = 3'b110;
    localparam logic [OPW-1:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational 8-op ALU, unsigned, modulo 2^WIDTH.
//   a, b  : operands (WIDTH)
//   op    : op code (OPW)
//   y     : result (WIDTH)
//   carry : add carry-out, sub borrow, shift-out bit for shl/shr, else 0
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide  = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                y     = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_SUB: begin
                // The extra top bit goes high exactly when a < b (borrow).
                wide  = {1'b0, a} - {1'b0, b};
                y     = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
            OP_OR:  y = a | b;
            OP_SHL: begin
                y     = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            OP_SHR: begin
                y     = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            OP_PASSB: y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/calc_seq_core.sv
// calc_seq_core: self-sequencing calculator. One start pulse loads A/B into a
// small register file, runs one ALU op and posts result + flags with a done pulse.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted only while idle (not queued while busy)
//   acc_mode  : at accept, take operand A from the previous result R2
//   op        : ALU op code, sampled at accept
//   in1, in2  : operands A and B, sampled at accept
//   busy      : high from the accept edge until the sequencer is idle again
//   done      : one-cycle pulse, out/zero/carry freshly valid
//   out       : registered result, held until the next done
//   zero      : out == 0
//   carry     : ALU carry/borrow/shift-out flag
//   fsm_state : current sequencer state, for observation
// Handshake: a request is taken on a rising edge where start=1 and busy=0; the
// result follows with done exactly two edges later, no backpressure.
module calc_seq_core
    import calc_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_mode,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output state_t           fsm_state
);

    localparam bit USE_ACC = (ACC_EN != 0);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a     (r0),
        .b     (r1),
        .op    (op_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed four-step sequence, only IDLE waits
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD_B;
            ST_LOAD_B: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state != ST_IDLE);
        fsm_state = state;
    end

    // Datapath and result registers. B goes through b_q so the input bus is
    // free immediately after accept; R1 is written one step later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0    <= '0;
            r1    <= '0;
            r2    <= '0;
            b_q   <= '0;
            op_q  <= '0;
            out   <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        r0   <= (USE_ACC && acc_mode) ? r2 : in1;
                        b_q  <= in2;
                    end
                end
                ST_LOAD_B: r1 <= b_q;
                ST_EXEC: begin
                    r2    <= alu_y;
                    out   <= alu_y;
                    zero  <= (alu_y == '0);
                    carry <= alu_carry;
                    done  <= 1'b1;
                end
                ST_DONE: done <= 1'b0;
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: three instances share stimulus (3-bit with
// accumulate, 3-bit without accumulate, 8-bit with accumulate); the 3-bit
// instances see the low bits of the operand buses.
module tb_calc_seq_core;
    import calc_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       acc_mode;
    logic [2:0] op;
    logic [7:0] in1;
    logic [7:0] in2;

    logic       busy_a, done_a, zero_a, carry_a;
    logic [2:0] out_a;
    state_t     st_a;
    logic       busy_b, done_b, zero_b, carry_b;
    logic [2:0] out_b;
    state_t     st_b;
    logic       busy_c, done_c, zero_c, carry_c;
    logic [7:0] out_c;
    state_t     st_c;

    int checks = 0;
    int errors = 0;

    calc_seq_core #(.WIDTH(3), .ACC_EN(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .op(op),
        .in1(in1[2:0]), .in2(in2[2:0]), .busy(busy_a), .done(done_a),
        .out(out_a), .zero(zero_a), .carry(carry_a), .fsm_state(st_a)
    );

    calc_seq_core #(.WIDTH(3), .ACC_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .op(op),
        .in1(in1[2:0]), .in2(in2[2:0]), .busy(busy_b), .done(done_b),
        .out(out_b), .zero(zero_b), .carry(carry_b), .fsm_state(st_b)
    );

    calc_seq_core #(.WIDTH(8), .ACC_EN(1)) u_dut_c (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .op(op),
        .in1(in1), .in2(in2), .busy(busy_c), .done(done_c),
        .out(out_c), .zero(zero_c), .carry(carry_c), .fsm_state(st_c)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned m_r2[3];
    int unsigned m_w[3]   = '{3, 3, 8};
    bit          m_acc[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned e_out[3];
    bit          e_zero[3];
    bit          e_carry[3];

    task automatic predict(input bit acc, input logic [2:0] opc,
                           input logic [7:0] a8, input logic [7:0] b8);
        for (int i = 0; i < 3; i++) begin
            int unsigned modv;
            int unsigned a;
            int unsigned b;
            int unsigned r;
            bit          c;
            modv = 32'd1 << m_w[i];
            a = (acc && m_acc[i]) ? m_r2[i] : (int'(a8) % modv);
            b = int'(b8) % modv;
            r = 0;
            c = 1'b0;
            case (opc)
                3'd0: begin r = a + b; c = (r >= modv); end
                3'd1: begin r = a + modv - b; c = (a < b); end
                3'd2: r = a & b;
                3'd3: r = a ^ b;
                3'd4: r = a | b;
                3'd5: begin r = a * 2; c = (a >= modv / 2); end
                3'd6: begin r = a / 2; c = (a % 2 == 1); end
                default: r = b;
            endcase
            r = r % modv;
            e_out[i]   = r;
            e_zero[i]  = (r == 0);
            e_carry[i] = c;
            m_r2[i]    = r;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_r2[i] = 0;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_results();
        chk("out_a", 32'(out_a), e_out[0]);
        chk("zero_a", 32'(zero_a), 32'(e_zero[0]));
        chk("carry_a", 32'(carry_a), 32'(e_carry[0]));
        chk("out_b", 32'(out_b), e_out[1]);
        chk("zero_b", 32'(zero_b), 32'(e_zero[1]));
        chk("carry_b", 32'(carry_b), 32'(e_carry[1]));
        chk("out_c", 32'(out_c), e_out[2]);
        chk("zero_c", 32'(zero_c), 32'(e_zero[2]));
        chk("carry_c", 32'(carry_c), 32'(e_carry[2]));
    endtask

    // ---------------- driver ----------------
    // One full transaction with the fixed timing: accept at edge n, done seen
    // after edge n+2, idle again after edge n+3.
    task automatic do_op(input bit acc, input logic [2:0] opc,
                         input logic [7:0] a8, input logic [7:0] b8);
        @(negedge clk);
        start = 1'b1; acc_mode = acc; op = opc; in1 = a8; in2 = b8;
        predict(acc, opc, a8, b8);
        @(posedge clk); #1;
        start = 1'b0;
        // scramble inputs after accept; they must not matter
        in1 = 8'($urandom); in2 = 8'($urandom); op = 3'($urandom); acc_mode = 1'($urandom);
        chk("busy_n0", 32'(busy_a), 1);
        chk("done_n0", 32'(done_a), 0);
        @(posedge clk); #1;
        chk("busy_n1", 32'(busy_a), 1);
        chk("done_n1", 32'(done_a), 0);
        @(posedge clk); #1;
        chk("busy_n2", 32'(busy_a), 1);
        chk("done_n2_a", 32'(done_a), 1);
        chk("done_n2_b", 32'(done_b), 1);
        chk("done_n2_c", 32'(done_c), 1);
        chk_results();
        @(posedge clk); #1;
        chk("busy_n3", 32'(busy_a), 0);
        chk("done_n3", 32'(done_a), 0);
        chk("busy_n3_c", 32'(busy_c), 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit         acc;
        logic [2:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] eo;
        bit         ec;
        bit         ez;
    } vec_t;

    vec_t vt[5];
    logic [4:0] exp_q[$];   // {carry, zero, out} of the 3-bit accumulate instance

    initial begin
        int n_done;
        logic [4:0] e;

        vt[0] = '{acc: 1'b0, opc: OP_ADD, a: 8'd5, b: 8'd6, eo: 3'd3, ec: 1'b1, ez: 1'b0};
        vt[1] = '{acc: 1'b0, opc: OP_SUB, a: 8'd2, b: 8'd5, eo: 3'd5, ec: 1'b1, ez: 1'b0};
        vt[2] = '{acc: 1'b0, opc: OP_XOR, a: 8'd7, b: 8'd7, eo: 3'd0, ec: 1'b0, ez: 1'b1};
        vt[3] = '{acc: 1'b0, opc: OP_ADD, a: 8'd3, b: 8'd2, eo: 3'd5, ec: 1'b0, ez: 1'b0};
        vt[4] = '{acc: 1'b1, opc: OP_ADD, a: 8'd7, b: 8'd1, eo: 3'd6, ec: 1'b0, ez: 1'b0};

        rst = 1'b1; start = 1'b0; acc_mode = 1'b0; op = '0; in1 = '0; in2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_out", 32'(out_a), 0);
        chk("rst_zero", 32'(zero_a), 0);
        chk("rst_carry", 32'(carry_a), 0);
        chk("rst_state", 32'(st_a), 32'(ST_IDLE));
        chk("rst_out_c", 32'(out_c), 0);
        @(negedge clk); rst = 1'b0;

        // table of directed vectors
        for (int i = 0; i < 5; i++) begin
            do_op(vt[i].acc, vt[i].opc, vt[i].a, vt[i].b);
            chk("vec_out", 32'(out_a), 32'(vt[i].eo));
            chk("vec_carry", 32'(carry_a), 32'(vt[i].ec));
            chk("vec_zero", 32'(zero_a), 32'(vt[i].ez));
        end
        // without accumulate, the last vector is 7+1 = 0 with carry
        chk("noacc_out", 32'(out_b), 0);
        chk("noacc_carry", 32'(carry_b), 1);

        // start held high with changing operands: one accept per 4 edges
        n_done = 0;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            start = 1'b1; acc_mode = 1'b0; op = OP_ADD;
            in1 = 8'($urandom); in2 = 8'($urandom);
            if (k % 4 == 0) begin
                predict(1'b0, OP_ADD, in1, in2);
                exp_q.push_back({e_carry[0], e_zero[0], e_out[0][2:0]});
            end
            @(posedge clk); #1;
            if (done_a) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("hold_extra_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hold_result", 32'({carry_a, zero_a, out_a}), 32'(e));
                end
            end
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        chk("hold_done_count", 32'(n_done), 4);
        chk("hold_idle", 32'(busy_a), 0);

        // reset during EXEC after a prior result of 4
        do_op(1'b0, OP_ADD, 8'd2, 8'd2);
        chk("pre_rst_out", 32'(out_a), 4);
        @(negedge clk);
        start = 1'b1; acc_mode = 1'b0; op = OP_ADD; in1 = 8'd1; in2 = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_state", 32'(st_a), 32'(ST_EXEC));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out", 32'(out_a), 0);
        chk("abort_done", 32'(done_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("abort_done_later", 32'(done_a), 0);
        // accumulate now reads the cleared R2
        do_op(1'b1, OP_ADD, 8'd7, 8'd3);
        chk("post_rst_acc", 32'(out_a), 3);

        // reset and start on the same edge: reset wins
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_start_busy", 32'(busy_a), 0);
        chk("rst_start_done", 32'(done_a), 0);

        // exhaustive 3-bit operands x all ops
        for (int o = 0; o < 8; o++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++)
                    do_op(1'b0, 3'(o), 8'(a), 8'(b));

        // random traffic, full 8-bit operands, random accumulate
        for (int i = 0; i < 2000; i++)
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
